// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 16-bit pipelined core.
// It drives the enables, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers.
// It handles window-aware load-use stalls, branch squash and memory-wait freezes.
// It also keeps a saturating stall counter and a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [1:0]       id_window,
    input  logic [2:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [1:0]       ex_window,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_t;

    // The flush counter only ever holds FLUSH_CYCLES-1 down to 1.
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WC_W = (MAX_MEM_WAIT > 1) ? $clog2(MAX_MEM_WAIT + 1) : 1;
    localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MAX_MEM_WAIT);

    state_t            state_q, state_d;
    state_t            resume_q, resume_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic              lu;

    // Load-use hazard only applies when both instructions share a register window.
    assign lu = ex_memread & ex_regwrite & (ex_window == id_window) &
                ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

    // Mealy pipeline controls and next-state selection. Priority: mem_busy > branch > load-use.
    always_comb begin
        pc_en         = 1'b0;
        ifid_en       = 1'b0;
        ifid_flush    = 1'b0;
        idex_en       = 1'b0;
        idex_bubble   = 1'b0;
        exmem_en      = 1'b0;
        state_d       = state_q;
        resume_d      = resume_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;

        case (state_q)
            ST_FLUSH: begin
                if (mem_busy) begin
                    resume_d   = ST_FLUSH;
                    wait_cnt_d = '0;
                    state_d    = ST_MEM_WAIT;
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_en     = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_en    = 1'b1;
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                    if (flush_cnt_q <= FC_W'(1)) state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                // Fully frozen, including the cycle busy drops.
                if (!mem_busy) begin
                    state_d = resume_q;
                end else begin
                    if (wait_cnt_q != WC_MAX) wait_cnt_d = wait_cnt_q + WC_W'(1);
                    if (wait_cnt_q == WC_MAX) mem_timeout_d = 1'b1;
                end
            end
            default: begin
                if (mem_busy) begin
                    resume_d   = ST_RUN;
                    wait_cnt_d = '0;
                    state_d    = ST_MEM_WAIT;
                end else if (ex_branch_taken) begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_en     = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_en    = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        flush_cnt_d = FC_INIT;
                        state_d     = ST_FLUSH;
                    end
                end else if (lu) begin
                    idex_en     = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_en    = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                end
                // The unused encoding drives RUN outputs but only returns to RUN.
                if (state_q != ST_RUN) begin
                    state_d     = ST_RUN;
                    resume_d    = resume_q;
                    wait_cnt_d  = wait_cnt_q;
                    flush_cnt_d = flush_cnt_q;
                end
            end
        endcase

        stall_count_d = stall_count_q;
        if (!pc_en && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    // State, counters and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            resume_q      <= ST_RUN;
            flush_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            resume_q      <= resume_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;
    assign mem_timeout = mem_timeout_q;

endmodule
